// File: rtl/spi_xfer_sequencer.sv
// spi_xfer_sequencer: Wishbone master that configures a simple_spi_top core
// once after reset, then runs each requested byte as a full SPI exchange
// (write SPDR, poll SPSR, read SPDR, clear SPIF). It also owns the
// active-low slave select and a sticky ack-timeout error.
module spi_xfer_sequencer #(
  parameter bit       CPOL        = 1'b0,
  parameter bit       CPHA        = 1'b0,
  parameter bit [1:0] SPR         = 2'b00,
  parameter bit [1:0] ESPR        = 2'b00,
  parameter int       ACK_TIMEOUT = 16
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [7:0] cmd_data_i,
  input  logic       cmd_last_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_data_o,
  output logic       rsp_err_o,
  output logic       ss_o,
  output logic       busy_o,
  output logic [7:0] spi_adr_o,
  output logic [7:0] spi_dat_o,
  input  logic [7:0] spi_dat_i,
  output logic       spi_we_o,
  output logic       spi_cyc_o,
  output logic       spi_stb_o,
  input  logic       spi_ack_i
);

  typedef enum logic [2:0] {
    S_CFG_CR, S_CFG_ER, S_READY, S_WR_DR, S_POLL, S_RD_DR, S_CLR, S_ERR
  } state_t;

  // SPI core register map
  localparam logic [7:0] ADR_SPCR = 8'd0;
  localparam logic [7:0] ADR_SPSR = 8'd1;
  localparam logic [7:0] ADR_SPDR = 8'd2;
  localparam logic [7:0] ADR_SPER = 8'd3;

  // SPE=1, MSTR=1, interrupts off; ICNT=0 so SPIF fires per byte
  localparam logic [7:0] SPCR_VAL = {1'b0, 1'b1, 1'b0, 1'b1, CPOL, CPHA, SPR};
  localparam logic [7:0] SPER_VAL = {6'b000000, ESPR};
  localparam logic [7:0] SPIF_CLR = 8'h80;

  // Count value at which the next ack-less cycle completes the timeout
  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t     r_state, w_state_next;
  logic       r_cyc, w_cyc_next;
  logic       r_stb, w_stb_next;
  logic       r_we, w_we_next;
  logic [7:0] r_adr, w_adr_next;
  logic [7:0] r_dat, w_dat_next;
  logic [7:0] r_cnt, w_cnt_next;
  logic [7:0] r_tx, w_tx_next;
  logic       r_last, w_last_next;
  logic       r_ss, w_ss_next;
  logic       r_rsp_valid, w_rsp_valid_next;
  logic [7:0] r_rsp_data, w_rsp_data_next;
  logic       r_err, w_err_next;

  logic       w_bus_state;
  logic [7:0] w_acc_adr;
  logic       w_acc_we;
  logic [7:0] w_acc_dat;

  // Decode which Wishbone access the current state performs
  always_comb begin
    w_bus_state = 1'b1;
    w_acc_adr   = 8'h00;
    w_acc_we    = 1'b0;
    w_acc_dat   = 8'h00;
    case (r_state)
      S_CFG_CR: begin w_acc_adr = ADR_SPCR; w_acc_we = 1'b1; w_acc_dat = SPCR_VAL; end
      S_CFG_ER: begin w_acc_adr = ADR_SPER; w_acc_we = 1'b1; w_acc_dat = SPER_VAL; end
      S_WR_DR:  begin w_acc_adr = ADR_SPDR; w_acc_we = 1'b1; w_acc_dat = r_tx;     end
      S_POLL:   begin w_acc_adr = ADR_SPSR; w_acc_we = 1'b0;                       end
      S_RD_DR:  begin w_acc_adr = ADR_SPDR; w_acc_we = 1'b0;                       end
      S_CLR:    begin w_acc_adr = ADR_SPSR; w_acc_we = 1'b1; w_acc_dat = SPIF_CLR; end
      default:  w_bus_state = 1'b0;
    endcase
  end

  // Next-state and next-output logic; a bus state issues its access when the
  // bus is idle, so every access is followed by one idle cycle
  always_comb begin
    w_state_next     = r_state;
    w_cyc_next       = r_cyc;
    w_stb_next       = r_stb;
    w_we_next        = r_we;
    w_adr_next       = r_adr;
    w_dat_next       = r_dat;
    w_cnt_next       = r_cnt;
    w_tx_next        = r_tx;
    w_last_next      = r_last;
    w_ss_next        = r_ss;
    w_rsp_valid_next = 1'b0;
    w_rsp_data_next  = r_rsp_data;
    w_err_next       = r_err;

    if (r_state == S_READY) begin
      if (cmd_valid_i) begin
        w_tx_next    = cmd_data_i;
        w_last_next  = cmd_last_i;
        w_ss_next    = 1'b0;
        w_state_next = S_WR_DR;
      end
    end else if (w_bus_state) begin
      if (!r_stb) begin
        w_cyc_next = 1'b1;
        w_stb_next = 1'b1;
        w_we_next  = w_acc_we;
        w_adr_next = w_acc_adr;
        w_dat_next = w_acc_dat;
        w_cnt_next = 8'h00;
      end else if (spi_ack_i) begin
        w_cyc_next = 1'b0;
        w_stb_next = 1'b0;
        w_we_next  = 1'b0;
        w_adr_next = 8'h00;
        w_dat_next = 8'h00;
        case (r_state)
          S_CFG_CR: w_state_next = S_CFG_ER;
          S_CFG_ER: w_state_next = S_READY;
          S_WR_DR:  w_state_next = S_POLL;
          S_POLL: begin
            // RFEMPTY clear means the exchanged byte is waiting
            if (!spi_dat_i[0]) w_state_next = S_RD_DR;
          end
          S_RD_DR: begin
            w_rsp_data_next = spi_dat_i;
            w_state_next    = S_CLR;
          end
          S_CLR: begin
            w_rsp_valid_next = 1'b1;
            if (r_last) w_ss_next = 1'b1;
            w_state_next = S_READY;
          end
          default: w_state_next = r_state;
        endcase
      end else if (r_cnt == TO_LAST) begin
        w_cyc_next   = 1'b0;
        w_stb_next   = 1'b0;
        w_we_next    = 1'b0;
        w_adr_next   = 8'h00;
        w_dat_next   = 8'h00;
        w_err_next   = 1'b1;
        w_ss_next    = 1'b1;
        w_state_next = S_ERR;
      end else begin
        w_cnt_next = r_cnt + 8'd1;
      end
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= S_CFG_CR;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= 8'h00;
      r_dat       <= 8'h00;
      r_cnt       <= 8'h00;
      r_tx        <= 8'h00;
      r_last      <= 1'b0;
      r_ss        <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'h00;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cyc       <= w_cyc_next;
      r_stb       <= w_stb_next;
      r_we        <= w_we_next;
      r_adr       <= w_adr_next;
      r_dat       <= w_dat_next;
      r_cnt       <= w_cnt_next;
      r_tx        <= w_tx_next;
      r_last      <= w_last_next;
      r_ss        <= w_ss_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_data  <= w_rsp_data_next;
      r_err       <= w_err_next;
    end
  end

  assign cmd_ready_o = (r_state == S_READY);
  assign busy_o      = (r_state != S_READY);
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_data_o  = r_rsp_data;
  assign rsp_err_o   = r_err;
  assign ss_o        = r_ss;
  assign spi_cyc_o   = r_cyc;
  assign spi_stb_o   = r_stb;
  assign spi_we_o    = r_we;
  assign spi_adr_o   = r_adr;
  assign spi_dat_o   = r_dat;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer with a behavioural SPI core model
// (1-cycle registered ack, loopback data with optional XOR, programmable
// number of empty SPSR polls, optional suppression of the SPDR write ack).
module tb_spi_xfer_sequencer;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic       cmd_last;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       ss;
  logic       busy;
  logic [7:0] spi_adr;
  logic [7:0] spi_dat_o;
  logic [7:0] spi_dat_i;
  logic       spi_we;
  logic       spi_cyc;
  logic       spi_stb;
  logic       spi_ack;

  // Second instance with non-default mode parameters
  logic       cmd_valid2;
  logic       cmd_ready2;
  logic       rsp_valid2;
  logic [7:0] rsp_data2;
  logic       rsp_err2;
  logic       ss2;
  logic       busy2;
  logic [7:0] spi_adr2;
  logic [7:0] spi_dat_o2;
  logic [7:0] spi_dat_i2;
  logic       spi_we2;
  logic       spi_cyc2;
  logic       spi_stb2;
  logic       spi_ack2;

  int n_checks;
  int n_fail;

  spi_xfer_sequencer u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_data_i(cmd_data), .cmd_last_i(cmd_last),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .ss_o(ss), .busy_o(busy),
    .spi_adr_o(spi_adr), .spi_dat_o(spi_dat_o), .spi_dat_i(spi_dat_i),
    .spi_we_o(spi_we), .spi_cyc_o(spi_cyc), .spi_stb_o(spi_stb),
    .spi_ack_i(spi_ack)
  );

  spi_xfer_sequencer #(.CPOL(1'b1), .CPHA(1'b1), .SPR(2'b11), .ESPR(2'b01)) u_dut2 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid2), .cmd_ready_o(cmd_ready2),
    .cmd_data_i(8'h00), .cmd_last_i(1'b0),
    .rsp_valid_o(rsp_valid2), .rsp_data_o(rsp_data2), .rsp_err_o(rsp_err2),
    .ss_o(ss2), .busy_o(busy2),
    .spi_adr_o(spi_adr2), .spi_dat_o(spi_dat_o2), .spi_dat_i(spi_dat_i2),
    .spi_we_o(spi_we2), .spi_cyc_o(spi_cyc2), .spi_stb_o(spi_stb2),
    .spi_ack_i(spi_ack2)
  );

  always #5 clk = ~clk;

  // ---------------- SPI core model for u_dut ----------------
  int         empty_polls;
  logic [7:0] rx_xor;
  logic       block_wr;
  int         polls_left;
  logic [7:0] last_tx;
  logic [7:0] log_adr [0:63];
  logic [7:0] log_dat [0:63];
  int         log_n;
  logic       blocked;

  assign blocked   = block_wr && spi_we && (spi_adr == 8'd2);
  assign spi_dat_i = (spi_adr == 8'd1) ? {7'b0, (polls_left != 0)} :
                     (spi_adr == 8'd2) ? (last_tx ^ rx_xor) : 8'h00;

  always @(posedge clk) begin
    if (rst) begin
      spi_ack    <= 1'b0;
      polls_left <= 0;
    end else begin
      spi_ack <= spi_cyc && spi_stb && !spi_ack && !blocked;
      if (spi_cyc && spi_stb && spi_ack) begin
        if (spi_we) begin
          if (log_n < 64) begin
            log_adr[log_n] <= spi_adr;
            log_dat[log_n] <= spi_dat_o;
            log_n          <= log_n + 1;
          end
          if (spi_adr == 8'd2) begin
            last_tx    <= spi_dat_o;
            polls_left <= empty_polls;
          end
        end else if (spi_adr == 8'd1 && polls_left != 0) begin
          polls_left <= polls_left - 1;
        end
      end
    end
  end

  // ---------------- write logger/acker for u_dut2 ----------------
  logic [7:0] log2_adr [0:7];
  logic [7:0] log2_dat [0:7];
  int         log2_n;
  assign spi_dat_i2 = 8'h00;

  always @(posedge clk) begin
    if (rst) begin
      spi_ack2 <= 1'b0;
    end else begin
      spi_ack2 <= spi_cyc2 && spi_stb2 && !spi_ack2;
      if (spi_cyc2 && spi_stb2 && spi_ack2 && spi_we2 && log2_n < 8) begin
        log2_adr[log2_n] <= spi_adr2;
        log2_dat[log2_n] <= spi_dat_o2;
        log2_n           <= log2_n + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns accept-to-response latency in cycles
  task automatic send_byte(input logic [7:0] d, input logic l, output int lat,
                           output logic [7:0] rx, output int ss_hi, output int rdy_hi);
    int guard;
    cmd_data  = d;
    cmd_last  = l;
    cmd_valid = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(posedge clk); @(negedge clk); guard++;
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat    = 0;
    ss_hi  = ss ? 1 : 0;
    rdy_hi = 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (rsp_valid) break;
      if (ss) ss_hi++;
      if (cmd_ready) rdy_hi++;
    end
    rx = rsp_data;
    $display("xfer tx=%02h last=%0d rx=%02h latency=%0d ss_o=%0d", d, l, rx, lat, ss);
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (!cmd_ready && cyc < 50) begin
      @(posedge clk); cyc++; @(negedge clk);
    end
  endtask

  initial begin
    int         lat;
    int         ss_hi;
    int         rdy_hi;
    int         cyc;
    int         mark;
    logic [7:0] rx;

    n_checks = 0; n_fail = 0;
    clk = 1'b0; rst = 1'b1;
    cmd_valid = 1'b0; cmd_data = 8'h00; cmd_last = 1'b0; cmd_valid2 = 1'b0;
    empty_polls = 0; rx_xor = 8'h00; block_wr = 1'b0;
    log_n = 0; log2_n = 0; last_tx = 8'h00;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_ss", ss, 1);
    chk("rst_busy", busy, 1);
    chk("rst_bus", {spi_cyc, spi_stb, spi_we, spi_adr, spi_dat_o}, 0);
    $display("reset applied: busy=%0d ss=%0d", busy, ss);

    // ---- configuration ----
    rst = 1'b0;
    wait_ready(cyc);
    $display("config done after %0d cycles", cyc);
    chk("cfg_ready_cycles", cyc, 6);
    chk("cfg_nwrites", log_n, 2);
    chk("cfg_spcr", {log_adr[0], log_dat[0]}, 16'h0050);
    chk("cfg_sper", {log_adr[1], log_dat[1]}, 16'h0300);
    chk("cfg_ss_idle", ss, 1);
    chk("cfg_busy", busy, 0);
    chk("mode_nwrites", log2_n, 2);
    chk("mode_spcr", {log2_adr[0], log2_dat[0]}, 16'h005F);
    chk("mode_sper", {log2_adr[1], log2_dat[1]}, 16'h0301);

    // ---- single byte, loopback ----
    mark = log_n;
    send_byte(8'hA5, 1'b1, lat, rx, ss_hi, rdy_hi);
    chk("single_latency", lat, 12);
    chk("single_rx", rx, 8'hA5);
    chk("single_ss_low_during", ss_hi, 0);
    chk("single_not_ready_busy", rdy_hi, 0);
    chk("single_ss_high_after", ss, 1);
    chk("single_spdr_wr", {log_adr[mark], log_dat[mark]}, 16'h02A5);
    chk("single_spsr_clr", {log_adr[mark+1], log_dat[mark+1]}, 16'h0180);
    @(posedge clk); @(negedge clk);
    chk("single_pulse_width", rsp_valid, 0);

    // ---- three-byte burst with empty polls ----
    empty_polls = 2;
    rx_xor      = 8'h3C;
    send_byte(8'h01, 1'b0, lat, rx, ss_hi, rdy_hi);
    chk("burst1_latency", lat, 18);
    chk("burst1_rx", rx, 8'h3D);
    chk("burst1_ss", ss_hi + (ss ? 1 : 0), 0);
    @(posedge clk); @(negedge clk);
    chk("burst1_pulse_width", rsp_valid, 0);
    chk("burst1_ss_gap", ss, 0);
    send_byte(8'h02, 1'b0, lat, rx, ss_hi, rdy_hi);
    chk("burst2_rx", rx, 8'h3E);
    chk("burst2_ss", ss_hi + (ss ? 1 : 0), 0);
    send_byte(8'h03, 1'b1, lat, rx, ss_hi, rdy_hi);
    chk("burst3_rx", rx, 8'h3F);
    chk("burst3_ss_during", ss_hi, 0);
    chk("burst3_ss_after", ss, 1);
    chk("burst3_latency", lat, 18);

    // ---- reset mid-POLL ----
    empty_polls = 1000;
    cmd_data = 8'h5A; cmd_last = 1'b0; cmd_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("poll_in_flight_stb", {spi_stb, spi_adr, spi_we}, {1'b1, 8'd1, 1'b0});
    chk("poll_ss_low", ss, 0);
    #1 rst = 1'b1;
    #1;
    chk("midrst_bus", {spi_cyc, spi_stb, spi_we, spi_adr, spi_dat_o}, 0);
    chk("midrst_ss", ss, 1);
    chk("midrst_busy_ready", {busy, cmd_ready}, 2'b10);
    chk("midrst_rsp_data", rsp_data, 0);
    $display("reset asserted mid-poll: ss=%0d stb=%0d", ss, spi_stb);
    empty_polls = 0;
    @(negedge clk);
    mark = log_n;
    rst = 1'b0;
    wait_ready(cyc);
    chk("recfg_cycles", cyc, 6);
    chk("recfg_spcr", {log_adr[mark], log_dat[mark]}, 16'h0050);
    chk("recfg_sper", {log_adr[mark+1], log_dat[mark+1]}, 16'h0300);

    // ---- ack timeout on SPDR write ----
    block_wr  = 1'b1;
    cmd_data  = 8'h77; cmd_last = 1'b1; cmd_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    cyc = 0;
    while (!spi_stb && cyc < 10) begin
      @(posedge clk); cyc++; @(negedge clk);
    end
    chk("to_stb_rose", spi_stb, 1);
    cyc = 0;
    while (!rsp_err && cyc < 100) begin
      @(posedge clk); cyc++; @(negedge clk);
    end
    $display("timeout: err after %0d cycles", cyc);
    chk("to_cycles", cyc, 16);
    chk("to_bus_dropped", {spi_cyc, spi_stb}, 0);
    chk("to_ss", ss, 1);
    chk("to_ready", cmd_ready, 0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("to_sticky", {rsp_err, cmd_ready, busy, spi_stb}, 4'b1010);
    cmd_valid = 1'b0;

    // ---- reset clears the sticky error ----
    rst = 1'b1;
    @(negedge clk);
    chk("err_cleared", rsp_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_xfer_sequencer.md
# spi_xfer_sequencer

Wishbone master that sequences the `simple_spi_top` register interface on behalf of one byte-stream requester. After reset it configures the SPI core once (SPCR, SPER). It then runs each requested byte as a full exchange: write SPDR, poll SPSR until the read FIFO is non-empty, read SPDR, clear SPIF. It also owns the slave-select line and the Wishbone ack-timeout error path. It sits between a local command source and the SPI core, in place of the I2C-to-Wishbone bridge as the SPI core's bus master.

## Interface

Parameters:

- `CPOL`, 0: SPCR[3].
- `CPHA`, 0: SPCR[2].
- `SPR`, 2'b00: SPCR[1:0], clock divider low bits.
- `ESPR`, 2'b00: SPER[1:0], extended divider bits.
- `ACK_TIMEOUT`, 16: cycles a Wishbone access may wait for `spi_ack_i` before an error is flagged (4..255).

Ports:

- `wb_clk_i` input 1: single clock. Block and SPI core run on this clock.
- `wb_rst_i` input 1: reset. Asynchronous, active-high.
- `cmd_valid_i` input 1: requester offers a TX byte.
- `cmd_ready_o` output 1: block accepts the byte this cycle (valid && ready = transfer).
- `cmd_data_i` input 8: TX byte.
- `cmd_last_i` input 1: deassert slave-select after this byte.
- `rsp_valid_o` output 1: one-cycle pulse; the RX byte is available.
- `rsp_data_o` output 8: RX byte, held until the next pulse.
- `rsp_err_o` output 1: sticky ack-timeout error. Cleared only by reset.
- `ss_o` output 1: active-low slave select.
- `busy_o` output 1: high in every state except READY.
- `spi_adr_o` output 8: SPI core register address (0 SPCR, 1 SPSR, 2 SPDR, 3 SPER).
- `spi_dat_o` output 8: write data to the SPI core.
- `spi_dat_i` input 8: read data from the SPI core.
- `spi_we_o`, `spi_cyc_o`, `spi_stb_o` output 1 each: Wishbone master controls.
- `spi_ack_i` input 1: Wishbone ack from the SPI core.

## Operation

Wishbone access rule:
- `cyc`, `stb`, `we`, `adr` and `dat` are registered and held until `spi_ack_i` is sampled high.
- All of them drop in the following cycle.
- Read data is captured in the ack cycle.

States and transitions:
- **CFG_CR**: write SPCR = {1'b0, 1'b1, 1'b0, 1'b1, CPOL, CPHA, SPR}. That is SPE=1, MSTR=1, interrupts off. → CFG_ER.
- **CFG_ER**: write SPER = {2'b00, 4'b0000, ESPR}. ICNT=0 means one byte per SPIF. → READY.
- **READY**: `cmd_ready_o`=1. On a transfer: latch data and last, drive `ss_o`=0, → WR_DR.
- **WR_DR**: write SPDR = latched byte. → POLL.
- **POLL**: read SPSR.
  - If bit0 (RFEMPTY)=0 → RD_DR.
  - Otherwise issue the read again; idle cycles between reads are allowed but not required.
- **RD_DR**: read SPDR. Capture into `rsp_data_o`. → CLR.
- **CLR**: write SPSR = 8'h80, which clears SPIF.
  - In the cycle the CLR ack is sampled, pulse `rsp_valid_o` for one cycle.
  - If last was set, `ss_o`=1 in the next cycle.
  - → READY.
- **ERR**: entered from any access when ACK_TIMEOUT cycles pass without an ack.
  - Drop cyc/stb. Set `rsp_err_o`. `ss_o`=1.
  - Stay in ERR until reset; `cmd_ready_o`=0.

Boundary conditions:
- `cmd_valid_i` asserted while busy: the byte is not accepted. The requester must hold it.
- Back-to-back bytes with last=0: `ss_o` stays 0 across bytes.
- Timeout counter: resets at the start of every access and counts cycles with stb=1 and no ack. The error fires when the count equals ACK_TIMEOUT.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous), and the FSM → CFG_CR. Any in-flight SPI byte is abandoned.

## Timing

- Reset values: `cmd_ready_o`=0, `rsp_valid_o`=0, `rsp_data_o`=0, `rsp_err_o`=0, `ss_o`=1, `busy_o`=1, `spi_cyc_o`=`spi_stb_o`=`spi_we_o`=0, `spi_adr_o`=0, `spi_dat_o`=0.
- With a 1-cycle-ack slave, each access occupies 2 cycles (strobe plus ack), then 1 cycle of bus idle.
- First `cmd_ready_o`=1 occurs no earlier than 6 cycles after reset release.
- Per-byte latency from the accept cycle to `rsp_valid_o`: 3 accesses × 3 cycles + N_poll × 3 cycles + 3 cycles.
- `rsp_valid_o` is never asserted in two consecutive cycles.

## Test plan

- **Reset and config**: release reset with a 1-cycle-ack SPI model. Expect a write of 8'h50 to adr 0, then a write of 8'h00 to adr 3, then `cmd_ready_o`=1 and `ss_o`=1.
- **Single byte, loopback** (miso tied to mosi, real `simple_spi_top`): send 8'hA5 with last=1. Expect `rsp_data_o`=8'hA5 with `rsp_valid_o` pulsed once, SPSR written with 8'h80, and `ss_o` low for the transfer and high afterwards.
- **Three-byte burst** 8'h01, 8'h02, 8'h03 (last on the third): expect `ss_o` low continuously from the first accept to after the third response, and three rsp pulses in order.
- **Mode parameters**: CPOL=1, CPHA=1, SPR=2'b11, ESPR=2'b01. Expect SPCR write 8'h5F and SPER write 8'h01; sck idles high.
- **Ack timeout**: a stub never acks the SPDR write. Expect `rsp_err_o`=1 exactly ACK_TIMEOUT cycles after stb rose, cyc/stb low, `ss_o`=1, `cmd_ready_o` held 0.
- **Reset mid-POLL**: assert `wb_rst_i` while polling. Expect outputs at reset values in the same cycle; after release, the config sequence restarts.
